// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
//   arb_state_t  : arbiter FSM states
//   WT_*         : controller work-type encodings (bit2 = unsigned, [1:0] = size)
//   extend_load  : sign/zero extension of raw controller read data
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_IF = 2'd1,
      ST_WAIT_LS = 2'd2,
      ST_DRAIN   = 2'd3
   } arb_state_t;

   localparam logic [2:0] WT_B  = 3'b000;
   localparam logic [2:0] WT_H  = 3'b001;
   localparam logic [2:0] WT_W  = 3'b010;
   localparam logic [2:0] WT_BU = 3'b100;
   localparam logic [2:0] WT_HU = 3'b101;

   // The controller may leave stale bytes above the access size; only the
   // low byte/half is meaningful for sub-word loads.
   function automatic logic [31:0] extend_load(input logic [2:0] wt, input logic [31:0] d);
      logic [31:0] r;
      case (wt)
         WT_B:    r = {{24{d[7]}}, d[7:0]};
         WT_BU:   r = {24'h0, d[7:0]};
         WT_H:    r = {{16{d[15]}}, d[15:0]};
         WT_HU:   r = {16'h0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational request eligibility and priority select.
// Ports:
//   issue_ok    : arbiter idle, controller free, enabled, out of reset
//   starve_hit  : LS has won STARVE_LIMIT times in a row while IF waited
//   if_req/if_done, ls_req/ls_is_write/ls_done, rob_clear : request status
//   grant_if, grant_ls : at most one high; issue this cycle
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic issue_ok,
   input  logic starve_hit,
   input  logic rob_clear,
   input  logic if_req,
   input  logic if_done,
   input  logic ls_req,
   input  logic ls_is_write,
   input  logic ls_done,
   output logic grant_if,
   output logic grant_ls
);

   logic if_elig;
   logic ls_elig;

   // A requester still holds req in the cycle its done pulses; masking it
   // there stops the same access being issued twice.
   assign if_elig = if_req && !if_done && !rob_clear;
   assign ls_elig = ls_req && !ls_done && (ls_is_write || !rob_clear);

   assign grant_if = issue_ok && if_elig && (!ls_elig || starve_hit);
   assign grant_ls = issue_ok && ls_elig && !(if_elig && starve_hit);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch (IF) and load/store buffer (LS) onto the
// single byte-serial memory controller, tracks completion and returns
// data/done to the owner. Speculative reads are dropped on rob_clear;
// stores are never cancelled.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global freeze), rob_clear
//   if_req/if_addr -> if_done/if_data
//   ls_req/ls_is_write/ls_addr/ls_wdata/ls_type -> ls_done/ls_data
//   mc_new_task/mc_is_write/mc_addr/mc_wdata/mc_type -> controller
//   mc_ready/mc_working/mc_rdata <- controller
// Optional: define MEM_ARB_PERF_EN to add perf_if_grants, perf_ls_grants,
// perf_stall_cycles (saturating 32-bit counters).
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | free; may issue a request combinationally this cycle
// ST_WAIT_IF | IF word read in flight
// ST_WAIT_LS | LS load or store in flight
// ST_DRAIN   | flushed read still running in controller; swallow result
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3   // 2**CNT_W must exceed STARVE_LIMIT
)(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_clear,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_is_write,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic [2:0]  ls_type,
   output logic        ls_done,
   output logic [31:0] ls_data,
   output logic        mc_new_task,
   output logic        mc_is_write,
   output logic [31:0] mc_addr,
   output logic [31:0] mc_wdata,
   output logic [2:0]  mc_type,
   input  logic        mc_ready,
   input  logic        mc_working,
   input  logic [31:0] mc_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0] perf_if_grants,
   output logic [31:0] perf_ls_grants,
   output logic [31:0] perf_stall_cycles
`endif
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] starve_cnt;
   logic             cur_write_q;
   logic [2:0]       cur_type_q;
   logic             issue_ok, starve_hit;
   logic             grant_if, grant_ls;
   logic             if_done_d, ls_done_d;
   logic [31:0]      if_data_d, ls_data_d;

   // rst_in is included so nothing is issued while the controller is held
   // in the same reset.
   assign issue_ok   = rdy_in && rst_in && (state_q == ST_IDLE) && !mc_working;
   assign starve_hit = (starve_cnt == LIMIT);

   mem_arb_pick u_pick (
      .issue_ok    (issue_ok),
      .starve_hit  (starve_hit),
      .rob_clear   (rob_clear),
      .if_req      (if_req),
      .if_done     (if_done),
      .ls_req      (ls_req),
      .ls_is_write (ls_is_write),
      .ls_done     (ls_done),
      .grant_if    (grant_if),
      .grant_ls    (grant_ls)
   );

   always_comb begin
      mc_new_task = grant_if || grant_ls;
      mc_is_write = 1'b0;
      mc_addr     = '0;
      mc_wdata    = '0;
      mc_type     = '0;
      if (grant_if) begin
         mc_addr = if_addr;
         mc_type = WT_W;
      end else if (grant_ls) begin
         mc_is_write = ls_is_write;
         mc_addr     = ls_addr;
         mc_wdata    = ls_wdata;
         mc_type     = ls_type;
      end
   end

   always_comb begin
      state_d   = state_q;
      if_done_d = 1'b0;
      ls_done_d = 1'b0;
      if_data_d = if_data;
      ls_data_d = ls_data;
      case (state_q)
         ST_IDLE: begin
            if (grant_if)
               state_d = ST_WAIT_IF;
            else if (grant_ls)
               state_d = ST_WAIT_LS;
         end
         ST_WAIT_IF: begin
            // A flush in the same cycle as mc_ready drops the data.
            if (rob_clear) begin
               state_d = ST_DRAIN;
            end else if (mc_ready) begin
               if_data_d = mc_rdata;
               if_done_d = if_req;
               state_d   = ST_IDLE;
            end
         end
         ST_WAIT_LS: begin
            if (cur_write_q) begin
               if (!mc_working) begin
                  ls_done_d = ls_req;
                  state_d   = ST_IDLE;
               end
            end else if (rob_clear) begin
               state_d = ST_DRAIN;
            end else if (mc_ready) begin
               ls_data_d = extend_load(cur_type_q, mc_rdata);
               ls_done_d = ls_req;
               state_d   = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!mc_working)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= ST_IDLE;
         if_done     <= 1'b0;
         ls_done     <= 1'b0;
         if_data     <= '0;
         ls_data     <= '0;
         cur_write_q <= 1'b0;
         cur_type_q  <= '0;
         starve_cnt  <= '0;
      end else if (rdy_in) begin
         state_q <= state_d;
         if_done <= if_done_d;
         ls_done <= ls_done_d;
         if_data <= if_data_d;
         ls_data <= ls_data_d;
         if (grant_ls) begin
            cur_write_q <= ls_is_write;
            cur_type_q  <= ls_type;
         end
         // Held at the limit so a store slipping past a flushed IF cannot
         // wrap it back below the threshold.
         if (grant_if || !if_req)
            starve_cnt <= '0;
         else if (grant_ls && !starve_hit)
            starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         perf_if_grants    <= '0;
         perf_ls_grants    <= '0;
         perf_stall_cycles <= '0;
      end else if (rdy_in) begin
         if (grant_if && perf_if_grants != '1)
            perf_if_grants <= perf_if_grants + 32'd1;
         if (grant_ls && perf_ls_grants != '1)
            perf_ls_grants <= perf_ls_grants + 32'd1;
         if ((if_req || ls_req) && !mc_new_task && perf_stall_cycles != '1)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single byte-serial memory controller between two requesters: instruction fetch (IF, word reads only) and load/store buffer (LS, loads and stores of byte/half/word). Selects one request, issues it to the controller as a one-cycle new_task, tracks completion and returns data/done to the owner. Handles rob_clear flush: discards speculative reads, never cancels stores. Sits between ICache/LSB and the memory controller.

Parameters:
STARVE_LIMIT, 4, consecutive LS grants while IF is pending before IF is forced to win
CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; low freezes all state
rob_clear  in  1  pipeline flush
if_req  in  1  IF request, held until if_done
if_addr  in  32  IF word address
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
ls_req  in  1  LS request, held until ls_done
ls_is_write  in  1  1 = store
ls_addr  in  32  LS address
ls_wdata  in  32  store data
ls_type  in  3  work type; bit2 = unsigned, [1:0] = 00 byte, 01 half, 10 word
ls_done  out  1  one-cycle pulse; ls_data valid for loads
ls_data  out  32  extended load data
mc_new_task  out  1  to controller new_task
mc_is_write  out  1  to controller is_write
mc_addr  out  32  to controller addr
mc_wdata  out  32  to controller data_in
mc_type  out  3  to controller work_type
mc_ready  in  1  controller real_ready_out
mc_working  in  1  controller is_working
mc_rdata  in  32  controller data_out

Behaviour:
- Reset (rst_in low, async): state IDLE; if_done, ls_done, if_data, ls_data, starvation counter all 0; mc_* outputs 0.
- rdy_in low: no state, counter or output register changes; mc_new_task forced 0.
- States: IDLE, WAIT_IF, WAIT_LS, DRAIN.
- IDLE issue (combinational, same cycle): mc_new_task = 1 when a request is eligible and mc_working = 0. Eligibility:
  - A read is ineligible while rob_clear is high.
  - A store is always eligible.
  - IF is also ineligible in the cycle its if_done pulses.
  - LS is also ineligible in the cycle its ls_done pulses.
- Selection: LS wins, except when IF is pending and counter == STARVE_LIMIT, in which case IF wins.
- Counter: +1 on each LS grant while if_req is high; cleared on an IF grant or when if_req is low.
- IF issue drives mc_type = 3'b010 and mc_is_write = 0. LS issue passes ls_type, ls_is_write and ls_wdata through.
- Next state after issue: WAIT_IF or WAIT_LS.
- WAIT_x, read: when mc_ready is sampled high, capture mc_rdata into x_data, pulse x_done next cycle, return to IDLE.
- WAIT_x, write: when mc_working is sampled 0, pulse ls_done next cycle, return to IDLE.
- Latency with io_buffer_full low, issue at cycle t: byte op done at t+2, half at t+3, word at t+5.
- rob_clear in WAIT_IF, or in WAIT_LS holding a load: go to DRAIN, no done pulse.
- DRAIN: stay at least 1 cycle, until mc_working = 0. Any mc_ready seen in DRAIN is swallowed. Then IDLE.
- rob_clear in WAIT_LS holding a store: ignored; the store completes and ls_done pulses normally.
- rob_clear in the same cycle as mc_ready: clear wins, data is dropped.
- Requester dropping req while in WAIT: the access is still completed or drained; no done pulse if req is low at completion.
- Reset mid-operation: immediate return to IDLE; the controller is reset by the same rst_in.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds outputs perf_if_grants (32), perf_ls_grants (32) and perf_stall_cycles (32). The stall counter increments each cycle a request is pending but not issued. All three reset to 0, saturate at all-ones and are frozen by rdy_in low.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum;
  - work-type constants WT_B = 3'b000, WT_H = 3'b001, WT_W = 3'b010, WT_BU = 3'b100, WT_HU = 3'b101.
- One sub-module, mem_arb_pick: combinational eligibility plus priority/starvation select; outputs grant_if and grant_ls.
- Counter and FSM stay in the top module.

Test Plan:
- if_req with if_addr = 0x100 alone, controller returns 0xDEADBEEF → mc_new_task at t with mc_type = 010; if_done at t+5 with if_data = 0xDEADBEEF.
- if_req and ls_req (LB, signed) held together continuously, STARVE_LIMIT = 4 → grant order LS, LS, LS, LS, IF, repeating.
- SB of 0xA5 to 0x20 → ls_done at t+2; rob_clear asserted at t+1 → ls_done still pulses.
- Word load issued at t, rob_clear at t+2 → DRAIN, no ls_done, IDLE once mc_working = 0; next IF issued the following cycle.
- rob_clear held high with if_req and a pending load → no issue. With a pending store instead → the store issues.
- rdy_in low for 3 cycles mid word read → completion shifts by 3 cycles, data intact. rst_in low mid-WAIT → all outputs 0 asynchronously.
